// File: rtl/bx_slot_scheduler_pkg.sv
// Shared definitions for the BX slot scheduler.
//   lock_state_e   : lock FSM encoding (UNLOCKED / CHECKING / LOCKED)
//   SLOTS_PER_BX   : fast cycles (slots) per 40 MHz bunch crossing
//   BX_W           : bunch-crossing counter width
//   BX_MAX_DEFAULT : last BX of an LHC orbit
package bx_slot_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_CHECKING = 2'd1,
        ST_LOCKED   = 2'd2
    } lock_state_e;

    localparam int SLOTS_PER_BX   = 4;
    localparam int BX_W           = 12;
    localparam int BX_MAX_DEFAULT = 3563;

endpackage

// File: rtl/bx_slot_scheduler_rr_arbiter.sv
// Combinational round-robin picker: the first asserted request at or after
// ptr_i, searching cyclically.
//   req_i    : request vector
//   ptr_i    : highest-priority index this cycle
//   gnt_o    : one-hot grant (zero when no request)
//   winner_o : index of the granted requester
//   any_o    : at least one request present
module bx_slot_scheduler_rr_arbiter #(
    parameter int NREQ  = 8,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [NREQ-1:0]  gnt_o,
    output logic [IDX_W-1:0] winner_o,
    output logic             any_o
);

    int idx;

    always_comb begin
        gnt_o    = '0;
        winner_o = '0;
        any_o    = 1'b0;
        idx      = 0;
        for (int k = 0; k < NREQ; k++) begin
            // modulo keeps the search cyclic for non-power-of-two NREQ
            idx = (int'(ptr_i) + k) % NREQ;
            if (!any_o && req_i[idx]) begin
                any_o      = 1'b1;
                gnt_o[idx] = 1'b1;
                winner_o   = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/bx_slot_scheduler.sv
// Time-division slot scheduler for the 4x fabric. Builds a 4-slot frame from
// strobe4x, qualifies strobe lock, counts BX and shares one slot bus among
// NREQ requesters with round-robin arbitration.
//   clock4x_i, reset_i (sync, active-high), strobe4x_i
//   req_i / req_data_i   : requests and their data words
//   gnt_o                : combinational one-hot grant
//   slot_valid_o, slot_header_o, slot_data_o, slot_index_o, frame_start_o
//   bx_count_o, locked_o, lock_lost_o, err_count_o
//
// state    | meaning
// UNLOCKED | waiting for any strobe to start qualification
// CHECKING | counting consecutive correctly spaced strobes
// LOCKED   | frame aligned, slots emitted, BX counted
module bx_slot_scheduler
    import bx_slot_scheduler_pkg::*;
#(
    parameter int NREQ        = 8,
    parameter int DATA_W      = 14,
    parameter int LOCK_FRAMES = 4,
    parameter int BX_MAX      = BX_MAX_DEFAULT,
    parameter int HEADER_EN   = 1
) (
    input  logic                   clock4x_i,
    input  logic                   reset_i,
    input  logic                   strobe4x_i,
    input  logic [NREQ-1:0]        req_i,
    input  logic [NREQ*DATA_W-1:0] req_data_i,
    output logic [NREQ-1:0]        gnt_o,
    output logic                   slot_valid_o,
    output logic                   slot_header_o,
    output logic [DATA_W-1:0]      slot_data_o,
    output logic [1:0]             slot_index_o,
    output logic                   frame_start_o,
    output logic [BX_W-1:0]        bx_count_o,
    output logic                   locked_o,
    output logic                   lock_lost_o,
    output logic [7:0]             err_count_o
);

    localparam int IDX_W = $clog2(NREQ);

    lock_state_e       state_q;
    logic [1:0]        phase_q, phase_d;
    logic [3:0]        good_cnt_q;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [BX_W-1:0]   bx_count_q;
    logic [7:0]        err_count_q;
    logic              lock_lost_q;
    logic              slot_valid_q, slot_header_q, frame_start_q;
    logic [DATA_W-1:0] slot_data_q;
    logic [1:0]        slot_index_q;

    logic              good, misplaced, missing, bad;
    logic              emit_en, hdr_slot;
    logic [NREQ-1:0]   arb_gnt;
    logic [IDX_W-1:0]  arb_winner;
    logic              arb_any;
    logic [DATA_W-1:0] arb_data;

    bx_slot_scheduler_rr_arbiter #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req_i    (req_i),
        .ptr_i    (ptr_q),
        .gnt_o    (arb_gnt),
        .winner_o (arb_winner),
        .any_o    (arb_any)
    );

    assign good      = strobe4x_i  && (phase_q == 2'd3);
    assign misplaced = strobe4x_i  && (phase_q != 2'd3);
    assign missing   = !strobe4x_i && (phase_q == 2'd3);
    assign bad       = misplaced || missing;

    // a bad strobe cycle while locked is the lock-loss cycle: nothing emitted
    assign emit_en  = (state_q == ST_LOCKED) && !bad;
    assign hdr_slot = (HEADER_EN != 0) && (phase_q == 2'd0);

    assign gnt_o    = (emit_en && !hdr_slot && !reset_i) ? arb_gnt : '0;
    assign arb_data = req_data_i[int'(arb_winner)*DATA_W +: DATA_W];
    assign phase_d  = strobe4x_i ? 2'd0 : phase_q + 2'd1;
    assign ptr_d    = (arb_winner == IDX_W'(NREQ-1)) ? '0 : arb_winner + IDX_W'(1);

    always_ff @(posedge clock4x_i) begin
        if (reset_i) begin
            state_q       <= ST_UNLOCKED;
            phase_q       <= '0;
            good_cnt_q    <= '0;
            ptr_q         <= '0;
            bx_count_q    <= '0;
            err_count_q   <= '0;
            lock_lost_q   <= 1'b0;
            slot_valid_q  <= 1'b0;
            slot_header_q <= 1'b0;
            slot_data_q   <= '0;
            slot_index_q  <= '0;
            frame_start_q <= 1'b0;
        end else begin
            phase_q     <= phase_d;
            lock_lost_q <= 1'b0;

            case (state_q)
                ST_UNLOCKED: begin
                    if (strobe4x_i) begin
                        state_q    <= ST_CHECKING;
                        good_cnt_q <= '0;
                    end
                end
                ST_CHECKING: begin
                    if (good) begin
                        if (good_cnt_q == 4'(LOCK_FRAMES-1)) state_q <= ST_LOCKED;
                        good_cnt_q <= good_cnt_q + 4'd1;
                    end else if (misplaced) begin
                        good_cnt_q <= '0;
                    end else if (missing) begin
                        state_q <= ST_UNLOCKED;
                    end
                end
                ST_LOCKED: begin
                    if (bad) begin
                        state_q     <= ST_UNLOCKED;
                        lock_lost_q <= 1'b1;
                        if (err_count_q != 8'hFF) err_count_q <= err_count_q + 8'd1;
                    end else if (good) begin
                        bx_count_q <= (bx_count_q == BX_W'(BX_MAX)) ? '0 : bx_count_q + BX_W'(1);
                    end
                end
                default: state_q <= ST_UNLOCKED;
            endcase

            slot_valid_q  <= 1'b0;
            slot_header_q <= 1'b0;
            frame_start_q <= 1'b0;
            slot_index_q  <= phase_q;
            if (emit_en) begin
                frame_start_q <= (phase_q == 2'd0);
                if (hdr_slot) begin
                    slot_valid_q  <= 1'b1;
                    slot_header_q <= 1'b1;
                    slot_data_q   <= DATA_W'(bx_count_q);
                end else if (arb_any) begin
                    slot_valid_q <= 1'b1;
                    slot_data_q  <= arb_data;
                    ptr_q        <= ptr_d;
                end
            end
        end
    end

    assign slot_valid_o  = slot_valid_q;
    assign slot_header_o = slot_header_q;
    assign slot_data_o   = slot_data_q;
    assign slot_index_o  = slot_index_q;
    assign frame_start_o = frame_start_q;
    assign bx_count_o    = bx_count_q;
    assign locked_o      = (state_q == ST_LOCKED);
    assign lock_lost_o   = lock_lost_q;
    assign err_count_o   = err_count_q;

endmodule

// File: tb/tb_bx_slot_scheduler.sv
module tb_bx_slot_scheduler;

    localparam int NREQ   = 8;
    localparam int DATA_W = 14;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   strobe;
    logic [NREQ-1:0]        req;
    logic [NREQ*DATA_W-1:0] req_data;
    logic [NREQ-1:0]        gnt;
    logic                   slot_valid, slot_header, frame_start;
    logic [DATA_W-1:0]      slot_data;
    logic [1:0]             slot_index;
    logic [11:0]            bx_count;
    logic                   locked, lock_lost;
    logic [7:0]             err_count;

    logic [NREQ-1:0]        gnt_seen;
    int                     n_checks = 0;
    int                     n_fail   = 0;
    int                     ew;
    int                     bx_exp;

    always #5 clk = ~clk;

    bx_slot_scheduler #(
        .NREQ        (NREQ),
        .DATA_W      (DATA_W),
        .LOCK_FRAMES (4),
        .BX_MAX      (3563),
        .HEADER_EN   (1)
    ) dut (
        .clock4x_i     (clk),
        .reset_i       (reset),
        .strobe4x_i    (strobe),
        .req_i         (req),
        .req_data_i    (req_data),
        .gnt_o         (gnt),
        .slot_valid_o  (slot_valid),
        .slot_header_o (slot_header),
        .slot_data_o   (slot_data),
        .slot_index_o  (slot_index),
        .frame_start_o (frame_start),
        .bx_count_o    (bx_count),
        .locked_o      (locked),
        .lock_lost_o   (lock_lost),
        .err_count_o   (err_count)
    );

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // one fast cycle: gnt is captured just before the edge, outputs read 1 ns after it
    task automatic cyc(input logic stb);
        strobe = stb;
        #1;
        gnt_seen = gnt;
        @(posedge clk);
        #1;
    endtask

    task automatic frame();
        cyc(1'b0);
        cyc(1'b0);
        cyc(1'b0);
        cyc(1'b1);
    endtask

    initial begin
        reset  = 1'b1;
        strobe = 1'b0;
        req    = 8'hFF;
        for (int i = 0; i < NREQ; i++) req_data[i*DATA_W +: DATA_W] = DATA_W'(32'h100 + i);

        // reset state, requests present but grant held off
        @(posedge clk);
        #1;
        repeat (3) cyc(1'b0);
        chk_val("rst_gnt",    32'(gnt_seen),   32'h0);
        chk_val("rst_locked", 32'(locked),     32'h0);
        chk_val("rst_valid",  32'(slot_valid), 32'h0);
        chk_val("rst_bx",     32'(bx_count),   32'h0);
        chk_val("rst_err",    32'(err_count),  32'h0);
        reset = 1'b0;
        req   = '0;

        // lock acquisition: first strobe enters CHECKING, 4 good strobes lock
        repeat (4) frame();
        chk_val("lock_pre",  32'(locked), 32'h0);
        frame();
        chk_val("lock_post", 32'(locked), 32'h1);

        // all requesting: header then rotating grants
        req    = 8'hFF;
        ew     = 0;
        bx_exp = 0;
        for (int f = 0; f < 3; f++) begin
            for (int p = 0; p < 4; p++) begin
                cyc(p == 3);
                chk_val("rr_valid", 32'(slot_valid), 32'h1);
                if (p == 0) begin
                    chk_val("hdr_gnt",   32'(gnt_seen),    32'h0);
                    chk_val("hdr_flag",  32'(slot_header), 32'h1);
                    chk_val("hdr_data",  32'(slot_data),   32'(bx_exp));
                    chk_val("hdr_frame", 32'(frame_start), 32'h1);
                end else begin
                    chk_val("rr_gnt",   32'(gnt_seen),    32'(1 << ew));
                    chk_val("rr_hdr",   32'(slot_header), 32'h0);
                    chk_val("rr_data",  32'(slot_data),   32'(32'h100 + ew));
                    chk_val("rr_index", 32'(slot_index),  32'(p));
                    chk_val("rr_frame", 32'(frame_start), 32'h0);
                    ew = (ew + 1) % NREQ;
                end
                if (p == 3) bx_exp++;
            end
        end
        chk_val("rr_bx", 32'(bx_count), 32'h3);

        // single requester 5; pointer afterwards must favour 6 over 5
        req = '0;
        req_data[5*DATA_W +: DATA_W] = 14'h1ABC;
        cyc(1'b0);
        req = 8'h20;
        cyc(1'b0);
        chk_val("one_gnt",   32'(gnt_seen),   32'h20);
        chk_val("one_valid", 32'(slot_valid), 32'h1);
        chk_val("one_data",  32'(slot_data),  32'h1ABC);
        req = '0;
        cyc(1'b0);
        chk_val("idle_gnt",   32'(gnt_seen),   32'h0);
        chk_val("idle_valid", 32'(slot_valid), 32'h0);
        req = 8'h60;
        cyc(1'b1);
        chk_val("ptr6_gnt",  32'(gnt_seen),  32'h40);
        chk_val("ptr6_data", 32'(slot_data), 32'h106);
        req = '0;

        // early strobe at phase 2
        cyc(1'b0);
        cyc(1'b0);
        req = 8'hFF;
        cyc(1'b1);
        chk_val("early_gnt",    32'(gnt_seen),   32'h0);
        chk_val("early_locked", 32'(locked),     32'h0);
        chk_val("early_lost",   32'(lock_lost),  32'h1);
        chk_val("early_err",    32'(err_count),  32'h1);
        chk_val("early_valid",  32'(slot_valid), 32'h0);
        req = '0;
        cyc(1'b0);
        chk_val("lost_pulse", 32'(lock_lost), 32'h0);
        cyc(1'b0);
        cyc(1'b1);
        repeat (3) frame();
        chk_val("relock_pre",  32'(locked), 32'h0);
        frame();
        chk_val("relock_post", 32'(locked), 32'h1);
        chk_val("relock_bx",   32'(bx_count), 32'h4);
        // request pending at the lock-loss cycle is still served in order: pointer is 7
        req = 8'hFF;
        cyc(1'b0);
        cyc(1'b0);
        chk_val("pend_gnt", 32'(gnt_seen), 32'h80);
        req = '0;
        cyc(1'b0);
        cyc(1'b1);

        // dropped strobe while locked
        repeat (4) cyc(1'b0);
        chk_val("drop_locked", 32'(locked),    32'h0);
        chk_val("drop_lost",   32'(lock_lost), 32'h1);
        chk_val("drop_err",    32'(err_count), 32'h2);
        repeat (5) frame();
        chk_val("drop_relock", 32'(locked), 32'h1);
        for (int k = 0; k < 254; k++) begin
            repeat (4) cyc(1'b0);
            if (k == 251) chk_val("err_254", 32'(err_count), 32'd254);
            repeat (5) frame();
        end
        chk_val("err_sat", 32'(err_count), 32'd255);
        chk_val("sat_bx",  32'(bx_count),  32'h5);

        // bx wrap at 3563
        repeat (3558) frame();
        chk_val("bx_max", 32'(bx_count), 32'd3563);
        frame();
        chk_val("bx_wrap", 32'(bx_count), 32'h0);
        cyc(1'b0);
        chk_val("wrap_hdr", 32'(slot_data), 32'h0);

        // reset mid-frame with requests active
        req   = 8'hFF;
        reset = 1'b1;
        cyc(1'b0);
        chk_val("mrst_gnt",    32'(gnt_seen),    32'h0);
        chk_val("mrst_valid",  32'(slot_valid),  32'h0);
        chk_val("mrst_hdr",    32'(slot_header), 32'h0);
        chk_val("mrst_data",   32'(slot_data),   32'h0);
        chk_val("mrst_index",  32'(slot_index),  32'h0);
        chk_val("mrst_frame",  32'(frame_start), 32'h0);
        chk_val("mrst_bx",     32'(bx_count),    32'h0);
        chk_val("mrst_locked", 32'(locked),      32'h0);
        chk_val("mrst_err",    32'(err_count),   32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
